branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised, pipelined successor to the combinational branch comparator. It accepts one conditional branch per cycle over a valid/ready handshake and evaluates all six RISC-V branch conditions at XLEN width. It also computes the target and fall-through PCs, flags mispredictions against the front-end prediction, and keeps a saturating mispredict counter. It sits between decode/issue and the fetch redirect logic.

Parameters:
XLEN, 32, operand/PC width in bits (>=8)
LATENCY, 1, pipeline depth: 1 = compare and register at output; 2 = register operands, then compare and register at output
CNT_W, 16, width of mispredict counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline kill
in_valid  in  1  branch presented
in_ready  out  1  unit can accept
in_funct3  in  3  branch type: BEQ=000 BNE=001 BLT=100 BGE=101 BLTU=110 BGEU=111
in_rs1  in  XLEN  operand 1
in_rs2  in  XLEN  operand 2
in_pc  in  XLEN  branch PC
in_imm  in  XLEN  sign-extended offset
in_pred_taken  in  1  front-end prediction
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_taken  out  1  branch condition true
out_mispredict  out  1  out_taken != predicted
out_illegal  out  1  funct3 not a branch type
out_redirect_pc  out  XLEN  correct next PC
count_clr  in  1  synchronous counter clear
mispredict_count  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (rst_n low, async): all stage valids 0; out_valid, out_taken, out_mispredict, out_illegal = 0; out_redirect_pc = 0; mispredict_count = 0. in_ready = 1 after reset release.
- Handshake: transfer on valid&&ready at each port. Each stage loads when it is empty or its downstream stage is taking its data in the same cycle. in_ready = !stage1_valid || stage1_advancing. The ready path is combinational, so full throughput is 1/cycle with no bubbles. Latency is LATENCY cycles from input transfer to out_valid.
- Output is held stable while out_valid && !out_ready.
- Compare: signed compare for BLT/BGE, unsigned for BLTU/BGEU, equality for BEQ/BNE. Full XLEN bits.
- Illegal funct3 (010, 011): out_illegal=1, out_taken=0, out_mispredict=0, out_redirect_pc = pc+4. Never holds a stale result.
- target = pc + imm, fallthrough = pc + 4, both mod 2^XLEN (wrap, no overflow flag). redirect_pc = taken ? target : fallthrough.
- mispredict = (taken != pred_taken) for legal types.
- flush: at the next edge all stage valids clear and out_valid drops. An input presented in the flush cycle is discarded. An output transfer in the flush cycle completes and is counted.
- Counter: increments by 1 on each output transfer with out_mispredict=1. Saturates at all-ones. count_clr takes priority over increment. flush does not affect the counter.
- Reset asserted mid-operation: in-flight entries are lost immediately; no partial output.

Test Plan:
- BLT rs1=0xFFFFFFFF, rs2=0x00000001, pc=0x100, imm=0x20, pred=0 -> taken=1, mispredict=1, redirect=0x120. BLTU with the same operands -> taken=0, redirect=0x104, mispredict=0.
- Back-to-back stream of 8 branches with out_ready=1, for LATENCY=1 and LATENCY=2 -> one result per cycle, in order, first out_valid exactly LATENCY cycles after the first accept.
- out_ready held low 3 cycles with pipeline full -> in_ready=0, outputs stable; on release, no result lost or duplicated.
- funct3=010 -> out_illegal=1, taken=0, redirect=pc+4. Then BEQ 5,5 -> taken=1 with no stale flags.
- pc=0xFFFFFFFC, imm=0x8, BNE 1,2 -> redirect=0x00000004. With CNT_W=2, drive 5 mispredicts -> count saturates at 3. count_clr together with a mispredict transfer -> count=0.
- flush with 2 entries in flight and a new input the same cycle -> out_valid=0 next cycle, no outputs emitted for those entries. Async rst_n pulse mid-stream -> all outputs zero immediately.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Pipelined conditional-branch resolver. It accepts one branch per cycle over a
// valid/ready handshake and evaluates the six RISC-V branch conditions at XLEN
// width. It produces the corrected next PC and flags mispredictions against the
// front-end prediction. A saturating counter tracks the delivered mispredicts.
//
// Parameters
//   XLEN    : operand / PC width (>= 8)
//   LATENCY : 1 = evaluate inputs directly into the output register
//             2 = register operands first, then evaluate into the output register
//             (any value other than 2 builds the 1-stage variant)
//   CNT_W   : mispredict counter width
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   flush                 : synchronous kill of all in-flight entries
//   in_valid / in_ready   : input handshake
//   in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken : branch operands
//   out_valid / out_ready : output handshake
//   out_taken, out_mispredict, out_illegal, out_redirect_pc : result
//   count_clr             : synchronous clear of mispredict_count (beats increment)
//   mispredict_count      : saturating count of delivered mispredicts
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_redirect_pc,
  input  logic             count_clr,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef struct packed {
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred;
  } op_t;

  op_t             in_op;
  op_t             eval_op;     // operands feeding the comparator this cycle
  logic            eval_valid;
  logic            out_free;    // output register may take new data this cycle

  logic            res_taken;
  logic            res_illegal;
  logic            res_mispredict;
  logic [XLEN-1:0] res_redirect;

  logic            out_valid_q, out_valid_d;
  logic            out_taken_q, out_taken_d;
  logic            out_mispredict_q, out_mispredict_d;
  logic            out_illegal_q, out_illegal_d;
  logic [XLEN-1:0] out_redirect_pc_q, out_redirect_pc_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign in_op    = {in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken};
  assign out_free = !out_valid_q || out_ready;

  generate
    if (LATENCY == 2) begin : g_lat2
      op_t  s1_op_q, s1_op_d;
      logic s1_valid_q, s1_valid_d;
      logic s1_advance;

      assign s1_advance = s1_valid_q && out_free;
      assign in_ready   = !s1_valid_q || s1_advance;
      assign eval_valid = s1_valid_q;
      assign eval_op    = s1_op_q;

      always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        if (flush) begin
          s1_valid_d = 1'b0;
        end else if (in_ready) begin
          s1_valid_d = in_valid;
          if (in_valid) s1_op_d = in_op;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid_q <= 1'b0;
          s1_op_q    <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_op_q    <= s1_op_d;
        end
      end
    end else begin : g_lat1
      assign in_ready   = out_free;
      assign eval_valid = in_valid;
      assign eval_op    = in_op;
    end
  endgenerate

  // Condition evaluation. Illegal encodings force a not-taken, non-mispredict
  // result so no stale flag from an earlier branch can leak through.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    case (eval_op.funct3)
      3'b000:  res_taken = (eval_op.rs1 == eval_op.rs2);
      3'b001:  res_taken = (eval_op.rs1 != eval_op.rs2);
      3'b100:  res_taken = ($signed(eval_op.rs1) <  $signed(eval_op.rs2));
      3'b101:  res_taken = ($signed(eval_op.rs1) >= $signed(eval_op.rs2));
      3'b110:  res_taken = (eval_op.rs1 <  eval_op.rs2);
      3'b111:  res_taken = (eval_op.rs1 >= eval_op.rs2);
      default: res_illegal = 1'b1;
    endcase
    res_mispredict = !res_illegal && (res_taken != eval_op.pred);
    // Both sums wrap modulo 2^XLEN by construction.
    res_redirect   = res_taken ? (eval_op.pc + eval_op.imm) : (eval_op.pc + XLEN'(4));
  end

  // Output register and mispredict counter next-state.
  always_comb begin
    out_valid_d       = out_valid_q;
    out_taken_d       = out_taken_q;
    out_mispredict_d  = out_mispredict_q;
    out_illegal_d     = out_illegal_q;
    out_redirect_pc_d = out_redirect_pc_q;
    count_d           = count_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_free) begin
      out_valid_d = eval_valid;
      // Payload only moves with a real entry, so a stalled result stays stable.
      if (eval_valid) begin
        out_taken_d       = res_taken;
        out_mispredict_d  = res_mispredict;
        out_illegal_d     = res_illegal;
        out_redirect_pc_d = res_redirect;
      end
    end

    // A transfer in a flush cycle still completes, so it still counts.
    if (count_clr) begin
      count_d = '0;
    end else if (out_valid_q && out_ready && out_mispredict_q && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the result payload is reset as well as the valid, because the
      // outputs are visible at the ports and must read zero out of reset.
      out_valid_q       <= 1'b0;
      out_taken_q       <= 1'b0;
      out_mispredict_q  <= 1'b0;
      out_illegal_q     <= 1'b0;
      out_redirect_pc_q <= '0;
      count_q           <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      out_valid_q       <= out_valid_d;
      out_taken_q       <= out_taken_d;
      out_mispredict_q  <= out_mispredict_d;
      out_illegal_q     <= out_illegal_d;
      out_redirect_pc_q <= out_redirect_pc_d;
      count_q           <= count_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_taken        = out_taken_q;
  assign out_mispredict   = out_mispredict_q;
  assign out_illegal      = out_illegal_q;
  assign out_redirect_pc  = out_redirect_pc_q;
  assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit. Two instances run side by side:
//   index 0 : LATENCY=1, CNT_W=2  (function, wrap, saturation, async reset)
//   index 1 : LATENCY=2, CNT_W=16 (streaming, back-pressure, flush)
// Every expected value is written by hand in the vector table or inline.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        taken;
    logic        mis;
    logic        ill;
    logic [31:0] redir;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            flush          [2];
  logic            in_valid       [2];
  logic            in_ready       [2];
  logic [2:0]      in_funct3      [2];
  logic [XLEN-1:0] in_rs1         [2];
  logic [XLEN-1:0] in_rs2         [2];
  logic [XLEN-1:0] in_pc          [2];
  logic [XLEN-1:0] in_imm         [2];
  logic            in_pred_taken  [2];
  logic            out_valid      [2];
  logic            out_ready      [2];
  logic            out_taken      [2];
  logic            out_mispredict [2];
  logic            out_illegal    [2];
  logic [XLEN-1:0] out_redirect_pc[2];
  logic            count_clr      [2];
  logic [1:0]      cnt0;
  logic [15:0]     cnt1;

  branch_resolve_unit #(.XLEN(XLEN), .LATENCY(1), .CNT_W(2)) u_l1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_funct3(in_funct3[0]),
    .in_rs1(in_rs1[0]), .in_rs2(in_rs2[0]), .in_pc(in_pc[0]), .in_imm(in_imm[0]),
    .in_pred_taken(in_pred_taken[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_taken(out_taken[0]),
    .out_mispredict(out_mispredict[0]), .out_illegal(out_illegal[0]),
    .out_redirect_pc(out_redirect_pc[0]),
    .count_clr(count_clr[0]), .mispredict_count(cnt0)
  );

  branch_resolve_unit #(.XLEN(XLEN), .LATENCY(2), .CNT_W(16)) u_l2 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_funct3(in_funct3[1]),
    .in_rs1(in_rs1[1]), .in_rs2(in_rs2[1]), .in_pc(in_pc[1]), .in_imm(in_imm[1]),
    .in_pred_taken(in_pred_taken[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_taken(out_taken[1]),
    .out_mispredict(out_mispredict[1]), .out_illegal(out_illegal[1]),
    .out_redirect_pc(out_redirect_pc[1]),
    .count_clr(count_clr[1]), .mispredict_count(cnt1)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input vec_t v);
    in_valid[d]      = 1'b1;
    in_funct3[d]     = v.f3;
    in_rs1[d]        = v.rs1;
    in_rs2[d]        = v.rs2;
    in_pc[d]         = v.pc;
    in_imm[d]        = v.imm;
    in_pred_taken[d] = v.pred;
  endtask

  task automatic expect_vec(input string tag, input int d, input vec_t v);
    check(tag,
          {28'b0, out_valid[d], out_taken[d], out_mispredict[d], out_illegal[d], out_redirect_pc[d]},
          {28'b0, 1'b1, v.taken, v.mis, v.ill, v.redir});
  endtask

  task automatic expect_empty(input string tag, input int d);
    check(tag, 64'(out_valid[d]), 64'd0);
  endtask

  task automatic expect_reset_outputs(input string tag, input int d);
    check(tag,
          {28'b0, out_valid[d], out_taken[d], out_mispredict[d], out_illegal[d], out_redirect_pc[d]},
          64'd0);
  endtask

  // Stream table: f3, rs1, rs2, pc, imm, pred | taken, mis, ill, redirect
  vec_t vt[8];
  // Directed vectors from the function checks.
  vec_t v_blt, v_bltu, v_ill, v_beq, v_wrap, v_mis;

  task automatic run_stream(input int d, input int lat);
    out_ready[d] = 1'b1;
    for (int t = 0; t < 8 + lat + 1; t++) begin
      if (t < 8) drive(d, vt[t]);
      else in_valid[d] = 1'b0;
      #1;
      check($sformatf("stream%0d.in_ready[%0d]", d, t), 64'(in_ready[d]), 64'd1);
      if (t >= lat && t - lat < 8) expect_vec($sformatf("stream%0d.out[%0d]", d, t), d, vt[t - lat]);
      else expect_empty($sformatf("stream%0d.empty[%0d]", d, t), d);
      step();
    end
  endtask

  logic [1:0] sat_exp [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    vt[0] = '{3'b000, 32'h3,        32'h3, 32'h200, 32'h10,       1'b1, 1'b1, 1'b0, 1'b0, 32'h210};
    vt[1] = '{3'b001, 32'h3,        32'h3, 32'h204, 32'h10,       1'b1, 1'b0, 1'b1, 1'b0, 32'h208};
    vt[2] = '{3'b100, 32'h80000000, 32'h0, 32'h208, 32'hFFFFFFF0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1F8};
    vt[3] = '{3'b101, 32'h80000000, 32'h0, 32'h20C, 32'h8,        1'b0, 1'b0, 1'b0, 1'b0, 32'h210};
    vt[4] = '{3'b110, 32'h80000000, 32'h0, 32'h210, 32'h40,       1'b1, 1'b0, 1'b1, 1'b0, 32'h214};
    vt[5] = '{3'b111, 32'h80000000, 32'h0, 32'h214, 32'h40,       1'b1, 1'b1, 1'b0, 1'b0, 32'h254};
    vt[6] = '{3'b101, 32'h5,        32'h5, 32'h218, 32'h100,      1'b1, 1'b1, 1'b0, 1'b0, 32'h318};
    vt[7] = '{3'b011, 32'h5,        32'h5, 32'h21C, 32'h100,      1'b1, 1'b0, 1'b0, 1'b1, 32'h220};

    v_blt  = '{3'b100, 32'hFFFFFFFF, 32'h1, 32'h100,      32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 32'h120};
    v_bltu = '{3'b110, 32'hFFFFFFFF, 32'h1, 32'h100,      32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104};
    v_ill  = '{3'b010, 32'h5,        32'h5, 32'h300,      32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h304};
    v_beq  = '{3'b000, 32'h5,        32'h5, 32'h400,      32'h8,  1'b1, 1'b1, 1'b0, 1'b0, 32'h408};
    v_wrap = '{3'b001, 32'h1,        32'h2, 32'hFFFFFFFC, 32'h8,  1'b1, 1'b1, 1'b0, 1'b0, 32'h4};
    v_mis  = '{3'b001, 32'h3,        32'h3, 32'h500,      32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h504};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; in_valid[d] = 1'b0; in_funct3[d] = 3'b000;
      in_rs1[d] = '0; in_rs2[d] = '0; in_pc[d] = '0; in_imm[d] = '0;
      in_pred_taken[d] = 1'b0; out_ready[d] = 1'b1; count_clr[d] = 1'b0;
    end

    // Reset state.
    step();
    step();
    expect_reset_outputs("reset.out0", 0);
    expect_reset_outputs("reset.out1", 1);
    check("reset.cnt0", 64'(cnt0), 64'd0);
    check("reset.cnt1", 64'(cnt1), 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset.in_ready0", 64'(in_ready[0]), 64'd1);
    check("reset.in_ready1", 64'(in_ready[1]), 64'd1);
    step();

    // Signed vs unsigned, illegal, no stale flags, PC wrap (LATENCY=1).
    drive(0, v_blt);   #1; check("func.in_ready", 64'(in_ready[0]), 64'd1); step();
    drive(0, v_bltu);  expect_vec("func.blt", 0, v_blt);   step();
    drive(0, v_ill);   expect_vec("func.bltu", 0, v_bltu); step();
    drive(0, v_beq);   expect_vec("func.illegal", 0, v_ill); step();
    drive(0, v_wrap);  expect_vec("func.beq_after_illegal", 0, v_beq); step();
    in_valid[0] = 1'b0; expect_vec("func.wrap", 0, v_wrap); step();
    expect_empty("func.drained", 0);

    // Back-to-back streams at both latencies.
    run_stream(0, 1);
    run_stream(1, 2);

    // Back-pressure on the 2-stage unit.
    out_ready[1] = 1'b0;
    drive(1, vt[0]); #1; check("stall.accept0", 64'(in_ready[1]), 64'd1); step();
    drive(1, vt[1]); #1; check("stall.accept1", 64'(in_ready[1]), 64'd1);
    expect_empty("stall.empty", 1); step();
    drive(1, vt[2]);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall.in_ready[%0d]", k), 64'(in_ready[1]), 64'd0);
      expect_vec($sformatf("stall.hold[%0d]", k), 1, vt[0]);
      step();
    end
    out_ready[1] = 1'b1;
    #1; check("stall.release_ready", 64'(in_ready[1]), 64'd1);
    expect_vec("stall.out0", 1, vt[0]); step();
    in_valid[1] = 1'b0;
    expect_vec("stall.out1", 1, vt[1]); step();
    expect_vec("stall.out2", 1, vt[2]); step();
    expect_empty("stall.drained", 1);

    // Counter saturation at CNT_W=2, then clear racing a mispredict transfer.
    count_clr[0] = 1'b1; in_valid[0] = 1'b0; out_ready[0] = 1'b1; step();
    count_clr[0] = 1'b0;
    for (int t = 0; t < 7; t++) begin
      if (t < 5) drive(0, v_mis);
      else in_valid[0] = 1'b0;
      #1;
      check($sformatf("sat.count[%0d]", t), 64'(cnt0), 64'(sat_exp[t]));
      step();
    end
    drive(0, v_mis); step();
    in_valid[0] = 1'b0; count_clr[0] = 1'b1;
    expect_vec("clr.out", 0, v_mis);
    check("clr.before", 64'(cnt0), 64'd3);
    step();
    count_clr[0] = 1'b0;
    check("clr.after", 64'(cnt0), 64'd0);
    step();
    check("clr.stays", 64'(cnt0), 64'd0);

    // Flush with two entries in flight and a new input in the same cycle.
    count_clr[1] = 1'b1; in_valid[1] = 1'b0; step();
    count_clr[1] = 1'b0;
    out_ready[1] = 1'b0;
    drive(1, vt[1]); step();
    drive(1, vt[0]); step();
    drive(1, vt[2]); out_ready[1] = 1'b1; flush[1] = 1'b1;
    #1; check("flush.in_ready", 64'(in_ready[1]), 64'd1);
    expect_vec("flush.out_in_flush_cycle", 1, vt[1]);
    check("flush.count_before", 64'(cnt1), 64'd0);
    step();
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_empty($sformatf("flush.empty[%0d]", k), 1);
      step();
    end
    check("flush.count", 64'(cnt1), 64'd1);

    // Async reset pulse mid-stream.
    drive(0, vt[1]); step();
    drive(0, vt[2]); expect_vec("arst.pre_out", 0, vt[1]); step();
    drive(0, vt[3]);
    #1; check("arst.pre_count", 64'(cnt0), 64'd1);
    #2; rst_n = 1'b0;
    #1;
    expect_reset_outputs("arst.out0", 0);
    expect_reset_outputs("arst.out1", 1);
    check("arst.count0", 64'(cnt0), 64'd0);
    in_valid[0] = 1'b0;
    #1; rst_n = 1'b1;
    step();
    expect_empty("arst.no_partial", 0);
    check("arst.in_ready", 64'(in_ready[0]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
